// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: time-multiplexed two-lane signed MAC with step activation.
// Weights live in an internal register file; one result per neuron over valid/ready.
module neuron_seq_ctrl #(
  parameter int                 NUM_IN   = 4,
  parameter int                 NUM_NEU  = 3,
  parameter logic signed [15:0] ON_VALUE = 16'sd256,
  localparam int NUM_W = NUM_NEU * NUM_IN,
  localparam int AW    = (NUM_W > 1) ? $clog2(NUM_W) : 1,
  localparam int IW    = (NUM_NEU > 1) ? $clog2(NUM_NEU) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NUM_IN-1:0] in_data,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [15:0]          cfg_data,
  output logic                 cfg_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_idx,
  output logic [15:0]          out_data,
  output logic [31:0]          out_sum
);
  localparam int NP = NUM_IN / 2;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int SW = $clog2(NUM_IN);

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_e;

  state_e             state_q;
  logic signed [15:0] w_q   [NUM_W];
  logic signed [15:0] smp_q [NUM_IN];
  logic [IW-1:0]      neuron_q;
  logic [PW-1:0]      pair_q;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] prod0, prod1;
  logic               in_ready_q, cfg_ready_q, out_valid_q;
  logic [IW-1:0]      out_idx_q;
  logic [15:0]        out_data_q;
  logic [31:0]        out_sum_q;
  logic               cfg_hit, last_pair, last_neu;

  always_comb begin
    int unsigned wb;
    int unsigned sb;
    wb    = 32'(neuron_q) * NUM_IN + 32'(pair_q) * 2;
    sb    = 32'(pair_q) * 2;
    // Operands sign-extended first so each product is the exact 32-bit value.
    prod0 = 32'(smp_q[SW'(sb)])     * 32'(w_q[AW'(wb)]);
    prod1 = 32'(smp_q[SW'(sb + 1)]) * 32'(w_q[AW'(wb + 1)]);
    acc_d = acc_q + prod0 + prod1;
  end

  assign cfg_hit   = cfg_we && ({1'b0, cfg_addr} < (AW+1)'(NUM_W));
  assign last_pair = (pair_q == PW'(NP - 1));
  assign last_neu  = (neuron_q == IW'(NUM_NEU - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < NUM_W; i++) w_q[i] <= '0;
      for (int unsigned k = 0; k < NUM_IN; k++) smp_q[k] <= '0;
      neuron_q    <= '0;
      pair_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      cfg_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_hit) w_q[cfg_addr] <= cfg_data;
          if (in_valid) begin
            for (int unsigned k = 0; k < NUM_IN; k++) smp_q[k] <= in_data[16*k +: 16];
            neuron_q    <= '0;
            pair_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            cfg_ready_q <= 1'b0;
            state_q     <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (last_pair) begin
            out_sum_q   <= acc_d;
            out_data_q  <= (acc_d <= 32'sd0) ? '0 : ON_VALUE;
            out_idx_q   <= neuron_q;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            pair_q <= pair_q + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_neu) begin
              in_ready_q  <= 1'b1;
              cfg_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              pair_q   <= '0;
              acc_q    <= '0;
              state_q  <= MAC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_ready = cfg_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Scoreboard bench for neuron_seq_ctrl: expected results queued at send, compared on output.
`timescale 1ns/1ps
module tb_neuron_seq_ctrl;
  localparam int NUM_IN  = 4;
  localparam int NUM_NEU = 3;
  localparam int NUM_W   = NUM_IN * NUM_NEU;
  localparam int AW      = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam int IW      = (NUM_NEU > 1) ? $clog2(NUM_NEU) : 1;
  localparam int P       = NUM_IN / 2;
  localparam logic signed [15:0] ON = 16'sd256;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [16*NUM_IN-1:0] in_data = '0;
  logic                 cfg_we = 1'b0;
  logic [AW-1:0]        cfg_addr = '0;
  logic [15:0]          cfg_data = '0;
  logic                 cfg_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [IW-1:0]        out_idx;
  logic [15:0]          out_data;
  logic [31:0]          out_sum;

  typedef struct {
    int          idx;
    logic [31:0] sum;
    logic [15:0] data;
    int          lat;
    logic        ird;
    logic        crd;
  } res_t;

  res_t               exp_q[$];
  res_t               obs_q[$];
  logic signed [15:0] wm [NUM_W];
  int                 n_pass = 0;
  int                 n_total = 0;

  neuron_seq_ctrl #(.NUM_IN(NUM_IN), .NUM_NEU(NUM_NEU), .ON_VALUE(ON)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_sum(out_sum)
  );

  always #5 clock = ~clock;

  task automatic clear_model();
    for (int i = 0; i < NUM_W; i++) wm[i] = '0;
  endtask

  task automatic write_w(input int a, input logic signed [15:0] d);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    if (a < NUM_W) wm[a] = d;
  endtask

  // Offers one vector; optional config write in the same cycle as the accept.
  task automatic send(input logic [16*NUM_IN-1:0] v, input bit cw, input int ca,
                      input logic signed [15:0] cd);
    int t;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 100) begin @(negedge clock); t++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = v;
    if (cw) begin
      cfg_we = 1'b1; cfg_addr = AW'(ca); cfg_data = cd;
      if (ca < NUM_W) wm[ca] = cd;
    end
    for (int n = 0; n < NUM_NEU; n++) begin
      res_t e;
      logic signed [31:0] s;
      s = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        logic signed [15:0] x;
        x = v[16*k +: 16];
        s = s + x * wm[n*NUM_IN + k];
      end
      e.idx = n; e.sum = s; e.data = (s <= 0) ? 16'h0000 : ON;
      e.lat = P + 1; e.ird = 1'b0; e.crd = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  // Drains n results with out_ready high; lat counts edges from accept/handshake.
  task automatic collect(input int n);
    int cnt, got, budget;
    cnt = 1; got = 0; budget = 0;
    out_ready = 1'b1;
    while (got < n && budget < 500) begin
      @(negedge clock);
      if (out_valid) begin
        res_t o;
        o.idx = int'(out_idx); o.sum = out_sum; o.data = out_data;
        o.lat = cnt; o.ird = in_ready; o.crd = cfg_ready;
        obs_q.push_back(o);
        got++; cnt = 0;
      end
      @(posedge clock); #1;
      cnt++; budget++;
    end
    if (got < n) begin
      n_total++;
      $display("FAIL collect_timeout: got %0d results, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    clear_model();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %b required 1", cfg_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else n_pass++;
    n_total++; if (out_idx !== '0) $display("FAIL rst_out_idx: got %0d required 0", out_idx); else n_pass++;
    n_total++; if (out_data !== 16'h0) $display("FAIL rst_out_data: got %0d required 0", out_data); else n_pass++;
    n_total++; if (out_sum !== 32'h0) $display("FAIL rst_out_sum: got %0d required 0", out_sum); else n_pass++;
  endtask

  task automatic test_basic();
    logic signed [31:0] csum [NUM_NEU];
    logic [15:0]        cdat [NUM_NEU];
    int                 i;
    csum[0] = 32'sd14; csum[1] = -32'sd14; csum[2] = 32'sd0;
    cdat[0] = 16'd256; cdat[1] = 16'd0;    cdat[2] = 16'd0;
    for (int a = NUM_W; a < (1 << AW); a++) write_w(a, 16'sd99);
    for (int k = 0; k < NUM_IN; k++) begin
      write_w(k, 16'sd1);
      write_w(NUM_IN + k, -16'sd1);
      write_w(2*NUM_IN + k, 16'sd0);
    end
    send({16'd5, 16'd4, 16'd3, 16'd2}, 1'b0, 0, 16'sd0);
    collect(NUM_NEU);
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data)
        $display("FAIL basic_result: idx=%0d sum=%0d data=%0d, required idx=%0d sum=%0d data=%0d",
                 o.idx, $signed(o.sum), o.data, e.idx, $signed(e.sum), e.data);
      else n_pass++;
      n_total++;
      if (o.sum !== csum[i] || o.data !== cdat[i])
        $display("FAIL basic_const: idx=%0d sum=%0d data=%0d, required sum=%0d data=%0d",
                 i, $signed(o.sum), o.data, csum[i], cdat[i]);
      else n_pass++;
      n_total++;
      if (o.lat !== e.lat) $display("FAIL basic_latency: idx=%0d got %0d cycles required %0d", i, o.lat, e.lat);
      else n_pass++;
      n_total++;
      if (o.ird !== 1'b0 || o.crd !== 1'b0)
        $display("FAIL basic_busy: idx=%0d in_ready=%b cfg_ready=%b required 0/0", i, o.ird, o.crd);
      else n_pass++;
      i++;
    end
    @(negedge clock);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_done: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] h_idx;
    logic [15:0]   h_data;
    logic [31:0]   h_sum;
    bit            stable;
    int            t;
    res_t          e;
    out_ready = 1'b0;
    send({16'd5, 16'd4, 16'd3, 16'd2}, 1'b0, 0, 16'sd0);
    t = 0;
    @(negedge clock);
    while (!out_valid && t < 20) begin @(negedge clock); t++; end
    h_idx = out_idx; h_data = out_data; h_sum = out_sum;
    e = exp_q.pop_front();
    n_total++;
    if (out_valid !== 1'b1 || int'(h_idx) !== e.idx || h_sum !== e.sum || h_data !== e.data)
      $display("FAIL bp_first: valid=%b idx=%0d sum=%0d data=%0d, required 1 idx=%0d sum=%0d data=%0d",
               out_valid, h_idx, $signed(h_sum), h_data, e.idx, $signed(e.sum), e.data);
    else n_pass++;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_idx !== h_idx || out_data !== h_data ||
          out_sum !== h_sum || in_ready !== 1'b0) stable = 1'b0;
    end
    n_total++;
    if (!stable)
      $display("FAIL bp_hold: valid=%b idx=%0d sum=%0d in_ready=%b, required held 1 idx=%0d sum=%0d in_ready=0",
               out_valid, out_idx, $signed(out_sum), in_ready, h_idx, $signed(h_sum));
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clock); #1;
    collect(NUM_NEU - 1);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      res_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      n_total++;
      if (o.idx !== x.idx || o.sum !== x.sum || o.data !== x.data || o.lat !== x.lat)
        $display("FAIL bp_rest: idx=%0d sum=%0d data=%0d lat=%0d, required idx=%0d sum=%0d data=%0d lat=%0d",
                 o.idx, $signed(o.sum), o.data, o.lat, x.idx, $signed(x.sum), x.data, x.lat);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < NUM_IN; k++) write_w(k, 16'sd32767);
    send({NUM_IN{16'h7FFF}}, 1'b0, 0, 16'sd0);
    collect(NUM_NEU);
    n_total++;
    if (obs_q.size() == 0 || obs_q[0].sum !== 32'hFFFC0004 || obs_q[0].data !== 16'h0)
      $display("FAIL wrap_const: sum=%0d data=%0d, required sum=-262140 data=0",
               (obs_q.size() > 0) ? $signed(obs_q[0].sum) : 0, (obs_q.size() > 0) ? obs_q[0].data : 16'h0);
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data)
        $display("FAIL wrap_result: idx=%0d sum=%0d data=%0d, required idx=%0d sum=%0d data=%0d",
                 o.idx, $signed(o.sum), o.data, e.idx, $signed(e.sum), e.data);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cfg_ignored();
    for (int r = 0; r < 2; r++) begin
      send({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 0, 16'sd0);
      cfg_we = 1'b1; cfg_addr = AW'(NUM_IN); cfg_data = 16'd100;
      collect(NUM_NEU);
      cfg_we = 1'b0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        res_t o, e;
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_total++;
        if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data || o.crd !== 1'b0)
          $display("FAIL cfg_busy: pass=%0d idx=%0d sum=%0d cfg_ready=%b, required idx=%0d sum=%0d cfg_ready=0",
                   r, o.idx, $signed(o.sum), o.crd, e.idx, $signed(e.sum));
        else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_simul();
    for (int k = 1; k < NUM_IN; k++) write_w(k, 16'sd0);
    send({16'd0, 16'd0, 16'd0, 16'd1}, 1'b1, 0, 16'sd7);
    collect(NUM_NEU);
    n_total++;
    if (obs_q.size() == 0 || obs_q[0].sum !== 32'd7)
      $display("FAIL simul_write: sum=%0d required 7", (obs_q.size() > 0) ? $signed(obs_q[0].sum) : 0);
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data)
        $display("FAIL simul_result: idx=%0d sum=%0d data=%0d, required idx=%0d sum=%0d data=%0d",
                 o.idx, $signed(o.sum), o.data, e.idx, $signed(e.sum), e.data);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < NUM_W; a++) write_w(a, 16'($urandom_range(0, 65535)));
    for (int r = 0; r < 3; r++) begin
      logic [16*NUM_IN-1:0] v;
      for (int k = 0; k < NUM_IN; k++) v[16*k +: 16] = 16'($urandom_range(0, 65535));
      send(v, 1'b0, 0, 16'sd0);
      collect(NUM_NEU);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        res_t o, e;
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_total++;
        if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data || o.lat !== e.lat)
          $display("FAIL b2b_result: vec=%0d idx=%0d sum=%0d data=%0d lat=%0d, required idx=%0d sum=%0d data=%0d lat=%0d",
                   r, o.idx, $signed(o.sum), o.data, o.lat, e.idx, $signed(e.sum), e.data, e.lat);
        else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_midreset();
    logic [16*NUM_IN-1:0] v;
    res_t o, e;
    for (int a = NUM_IN; a < 2*NUM_IN; a++) write_w(a, 16'sd3);
    send({16'd5, 16'd4, 16'd3, 16'd2}, 1'b0, 0, 16'sd0);
    collect(1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (o.idx !== e.idx || o.sum !== e.sum || o.data !== e.data)
        $display("FAIL mid_first: idx=%0d sum=%0d, required idx=%0d sum=%0d",
                 o.idx, $signed(o.sum), e.idx, $signed(e.sum));
      else n_pass++;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b required 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b required 1", in_ready); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL mid_cfg_ready: got %b required 1", cfg_ready); else n_pass++;
    n_total++; if (out_sum !== 32'h0) $display("FAIL mid_out_sum: got %0d required 0", out_sum); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < NUM_IN; k++) v[16*k +: 16] = 16'(k + 9);
    send(v, 1'b0, 0, 16'sd0);
    collect(NUM_NEU);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (o.idx !== e.idx || o.sum !== 32'h0 || o.data !== 16'h0 || o.sum !== e.sum)
        $display("FAIL mid_cleared: idx=%0d sum=%0d data=%0d, required idx=%0d sum=0 data=0",
                 o.idx, $signed(o.sum), o.data, e.idx);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_cfg_ignored();
    test_simul();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
- Time-multiplexed sequencer for the two-lane signed MAC-plus-step-activation neuron datapath.
- Accepts one input vector of NUM_IN samples and evaluates NUM_NEU neurons against it, two products per cycle.
- Holds all neuron weights in an internal configuration register file.
- Emits one thresholded result per neuron over a valid/ready output, in neuron order.

Parameters:
- NUM_IN, 4, inputs per neuron; even, >= 2.
- NUM_NEU, 3, neurons evaluated per input vector; >= 1.
- ON_VALUE, 256, activation output when the sum is positive; 16-bit signed.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input vector offered.
- in_ready  output  1  vector accepted when in_valid && in_ready.
- in_data  input  16*NUM_IN  signed samples; sample k is in bits [16k+15:16k].
- cfg_we  input  1  weight write strobe.
- cfg_addr  input  clog2(NUM_NEU*NUM_IN)  address = neuron*NUM_IN + input.
- cfg_data  input  16  signed weight.
- cfg_ready  output  1  high only in IDLE; writes take effect only when high.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_idx  output  clog2(NUM_NEU) (min 1)  neuron index of the result.
- out_data  output  16  activation result.
- out_sum  output  32  raw accumulated sum (debug).

Behaviour:
- Reset (async, reset=0): FSM=IDLE; all weights=0; in_ready=1; cfg_ready=1; out_valid=0; out_idx=0; out_data=0; out_sum=0; accumulator=0.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - A cfg_we write lands in the weight register at the next edge.
  - Out-of-range cfg_addr is ignored.
  - On in_valid: latch in_data, set neuron=0, pair=0, acc=0, go to MAC.
  - If cfg_we and an accept occur in the same cycle, the write is committed first, so the new weight is used for this vector.
- MAC:
  - in_ready=0, cfg_ready=0; cfg_we is ignored.
  - Each cycle: acc += in[2p]*w[n][2p] + in[2p+1]*w[n][2p+1].
  - Products are full 32-bit signed. Sums wrap modulo 2^32 with no saturation.
  - After pair NUM_IN/2-1, go to EMIT. The final acc goes to out_sum; out_data = (acc <= 0 signed) ? 0 : ON_VALUE.
- EMIT:
  - out_valid=1; out_idx, out_data and out_sum are held stable until out_ready.
  - On out_ready with neuron < NUM_NEU-1: neuron+1, pair=0, acc=0, back to MAC.
  - On out_ready with the last neuron: go to IDLE.
  - out_valid drops in the cycle after the handshake.
- Latency:
  - First result has out_valid high NUM_IN/2+1 cycles after the accept edge.
  - Each further result follows NUM_IN/2+1 cycles after the previous handshake.
  - Zero output backpressure: a full vector takes NUM_NEU*(NUM_IN/2+1) cycles to drain before in_ready returns.
- Backpressure: out_ready low stalls indefinitely with no state change; data stays stable.
- Reset mid-operation: returns to IDLE immediately. The in-flight vector and pending result are discarded, and weights are cleared.
- Activation boundary: a sum of exactly 0 gives 0. The most negative sum gives 0.

Test Plan:
- Reset, then write weights n0=(1,1,1,1), n1=(-1,-1,-1,-1), n2=(0,0,0,0); send in=(2,3,4,5), out_ready=1 -> results idx0 sum=14 data=256; idx1 sum=-14 data=0; idx2 sum=0 data=0. First out_valid 3 cycles after accept; in_ready returns after the idx2 handshake.
- Hold out_ready=0 for 10 cycles on idx0 -> out_valid stays 1, idx/data/sum stable; no progress to idx1; in_ready=0.
- Wrap: w0=(32767,32767,32767,32767), in=(32767,32767,32767,32767) -> sum=4*1073676289 mod 2^32 = -262140 -> data=0.
- cfg_we asserted during MAC on n1's address -> ignored; result unchanged; cfg_ready=0 throughout busy.
- Simultaneous cfg_we (addr 0, data 7) and in accept in IDLE with in=(1,0,0,0), other n0 weights 0 -> idx0 sum=7.
- Assert reset during the second MAC cycle of n1 -> out_valid=0, in_ready=1, all weights read 0 (next vector gives all sums 0).
